// File: rtl/regfile_wr_arbiter_if.sv
// Bundles the two writer request channels, the register-file write port and
// the decode-stage bypass query into one connection.
// master: writers/decode/register-file side; slave: the arbiter.
// Signals: p0_*/p1_* valid-ready write requests, rf_* registered write port,
// rs/rt_addr + byp_rs/rt bypass query, starve_cnt debug count.
interface regfile_wr_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          p0_valid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_data;
    logic          p0_ready;

    logic          p1_valid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_data;
    logic          p1_ready;

    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;

    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic          byp_rs;
    logic          byp_rt;

    logic [2:0]    starve_cnt;

    modport master (
        output p0_valid, p0_addr, p0_data,
        input  p0_ready,
        output p1_valid, p1_addr, p1_data,
        input  p1_ready,
        input  rf_we, rf_addr, rf_data,
        output rs_addr, rt_addr,
        input  byp_rs, byp_rt,
        input  starve_cnt
    );

    modport slave (
        input  p0_valid, p0_addr, p0_data,
        output p0_ready,
        input  p1_valid, p1_addr, p1_data,
        output p1_ready,
        output rf_we, rf_addr, rf_data,
        input  rs_addr, rt_addr,
        output byp_rs, byp_rt,
        output starve_cnt
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Purpose: shares the register-file write port between write-back (p0, fixed priority) and the mult/div unit (p1).
// Latency: one cycle from accept to rf_we/rf_addr/rf_data; ready and bypass flags are combinational.
// Backpressure: the losing port sees ready=0 and holds; p1 is forced through after STARVE_LIMIT lost cycles.
// Ports: clk, reset (sync, active-high), wr (slave modport): p0/p1 requests,
//        rf_we/rf_addr/rf_data write port, rs/rt_addr -> byp_rs/byp_rt, starve_cnt.
module regfile_wr_arbiter #(
    parameter int DW           = 32,
    parameter int AW           = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wr_arbiter_if.slave  wr
);
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic          force_p1;
    logic          p0_acc;
    logic          p1_acc;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;

    logic          rf_we_q;
    logic [AW-1:0] rf_addr_q;
    logic [DW-1:0] rf_data_q;
    logic [2:0]    starve_q;

    // Grant: readiness depends only on valids and the starvation count,
    // never on the requesting port's own address or data.
    always_comb begin
        wr.p0_ready = 1'b0;
        wr.p1_ready = 1'b0;
        force_p1    = (starve_q == LIMIT) && wr.p1_valid;
        if (!reset) begin
            if (force_p1) begin
                wr.p1_ready = 1'b1;
            end else if (wr.p0_valid) begin
                wr.p0_ready = 1'b1;
            end else begin
                wr.p1_ready = wr.p1_valid;
            end
        end
    end

    assign p0_acc   = wr.p0_valid && wr.p0_ready;
    assign p1_acc   = wr.p1_valid && wr.p1_ready;
    assign win_addr = p1_acc ? wr.p1_addr : wr.p0_addr;
    assign win_data = p1_acc ? wr.p1_data : wr.p0_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q  <= 3'd0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            if (wr.p1_valid && !wr.p1_ready) begin
                starve_q <= (starve_q == LIMIT) ? LIMIT : starve_q + 3'd1;
            end else begin
                starve_q <= 3'd0;
            end

            if (p0_acc || p1_acc) begin
                rf_addr_q <= win_addr;
                rf_data_q <= win_data;
                // Writes to $zero complete the handshake but never reach the file.
                rf_we_q   <= (win_addr != '0);
            end else begin
                rf_we_q   <= 1'b0;
            end
        end
    end

    assign wr.rf_we      = rf_we_q;
    assign wr.rf_addr    = rf_addr_q;
    assign wr.rf_data    = rf_data_q;
    assign wr.starve_cnt = starve_q;

    // Bypass compares decode sources against the write being presented to the file now.
    assign wr.byp_rs = rf_we_q && (rf_addr_q == wr.rs_addr) && (wr.rs_addr != '0);
    assign wr.byp_rt = rf_we_q && (rf_addr_q == wr.rt_addr) && (wr.rt_addr != '0);
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, p0 write, starvation forcing,
// $zero writes, bypass flags, same-address ordering and reset mid-operation.
module tb_regfile_wr_arbiter;
    logic clk;
    logic reset;
    int   vecs;
    int   miscomp;

    regfile_wr_arbiter_if #(.DW(32), .AW(5)) bus ();

    regfile_wr_arbiter #(.DW(32), .AW(5), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .wr    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            miscomp++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs    = 0;
        miscomp = 0;

        // 1. reset with both ports requesting
        reset        = 1'b1;
        bus.p0_valid = 1'b1;
        bus.p0_addr  = 5'd5;
        bus.p0_data  = 32'h0000_0005;
        bus.p1_valid = 1'b1;
        bus.p1_addr  = 5'd3;
        bus.p1_data  = 32'h0000_0003;
        bus.rs_addr  = 5'd0;
        bus.rt_addr  = 5'd0;
        #2;
        chk("rst_p0_ready", 32'(bus.p0_ready), 32'd0);
        chk("rst_p1_ready", 32'(bus.p1_ready), 32'd0);
        tick();
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_starve", 32'(bus.starve_cnt), 32'd0);
        chk("rst_rf_addr", 32'(bus.rf_addr), 32'd0);
        chk("rst_rf_data", bus.rf_data, 32'd0);
        reset        = 1'b0;
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
        tick();

        // 2. p0 alone
        bus.p0_valid = 1'b1;
        bus.p0_addr  = 5'd5;
        bus.p0_data  = 32'hDEAD_BEEF;
        #1;
        chk("p0only_p0_ready", 32'(bus.p0_ready), 32'd1);
        chk("p0only_p1_ready", 32'(bus.p1_ready), 32'd0);
        tick();
        bus.p0_valid = 1'b0;
        chk("p0only_rf_we", 32'(bus.rf_we), 32'd1);
        chk("p0only_rf_addr", 32'(bus.rf_addr), 32'd5);
        chk("p0only_rf_data", bus.rf_data, 32'hDEAD_BEEF);
        tick();
        chk("idle_rf_we", 32'(bus.rf_we), 32'd0);

        // 3. both held valid: p0 wins four times, then p1 is forced
        bus.p0_valid = 1'b1;
        bus.p0_addr  = 5'd10;
        bus.p0_data  = 32'h0000_00A0;
        bus.p1_valid = 1'b1;
        bus.p1_addr  = 5'd11;
        bus.p1_data  = 32'h0000_1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("starve_p0_ready_%0d", i), 32'(bus.p0_ready), 32'd1);
            chk($sformatf("starve_p1_ready_%0d", i), 32'(bus.p1_ready), 32'd0);
            chk($sformatf("starve_cnt_%0d", i), 32'(bus.starve_cnt), 32'(i));
            tick();
        end
        chk("force_p1_ready", 32'(bus.p1_ready), 32'd1);
        chk("force_p0_ready", 32'(bus.p0_ready), 32'd0);
        chk("force_starve", 32'(bus.starve_cnt), 32'd4);
        chk("force_rf_data_prev", bus.rf_data, 32'h0000_00A0);
        tick();
        bus.p0_valid = 1'b0;
        bus.p1_valid = 1'b0;
        chk("force_starve_clear", 32'(bus.starve_cnt), 32'd0);
        chk("force_rf_addr", 32'(bus.rf_addr), 32'd11);
        chk("force_rf_data", bus.rf_data, 32'h0000_1111);
        chk("force_rf_we", 32'(bus.rf_we), 32'd1);
        tick();

        // 4. p1 alone writing $zero
        bus.p1_valid = 1'b1;
        bus.p1_addr  = 5'd0;
        bus.p1_data  = 32'h0000_0055;
        bus.rs_addr  = 5'd0;
        #1;
        chk("zero_p1_ready", 32'(bus.p1_ready), 32'd1);
        tick();
        bus.p1_valid = 1'b0;
        chk("zero_rf_we", 32'(bus.rf_we), 32'd0);
        chk("zero_byp_rs", 32'(bus.byp_rs), 32'd0);
        chk("zero_starve", 32'(bus.starve_cnt), 32'd0);
        tick();

        // 5. bypass on addr 7
        bus.p0_valid = 1'b1;
        bus.p0_addr  = 5'd7;
        bus.p0_data  = 32'h0000_0077;
        bus.rs_addr  = 5'd7;
        bus.rt_addr  = 5'd8;
        #1;
        chk("byp_before", 32'(bus.byp_rs), 32'd0);
        tick();
        bus.p0_valid = 1'b0;
        #1;
        chk("byp_rs_hit", 32'(bus.byp_rs), 32'd1);
        chk("byp_rt_miss", 32'(bus.byp_rt), 32'd0);
        bus.rt_addr = 5'd7;
        #1;
        chk("byp_rt_hit", 32'(bus.byp_rt), 32'd1);
        tick();
        chk("byp_rs_idle", 32'(bus.byp_rs), 32'd0);
        chk("idle_rf_addr_hold", 32'(bus.rf_addr), 32'd7);
        chk("idle_rf_data_hold", bus.rf_data, 32'h0000_0077);

        // 6. same address on both ports: p0 first, then p1
        bus.p0_valid = 1'b1;
        bus.p0_addr  = 5'd9;
        bus.p0_data  = 32'hAAAA_0000;
        bus.p1_valid = 1'b1;
        bus.p1_addr  = 5'd9;
        bus.p1_data  = 32'hBBBB_0000;
        tick();
        bus.p0_valid = 1'b0;
        chk("same_first_data", bus.rf_data, 32'hAAAA_0000);
        chk("same_starve", 32'(bus.starve_cnt), 32'd1);
        #1;
        chk("same_p1_ready", 32'(bus.p1_ready), 32'd1);
        tick();
        bus.p1_valid = 1'b0;
        chk("same_second_data", bus.rf_data, 32'hBBBB_0000);
        chk("same_second_addr", 32'(bus.rf_addr), 32'd9);
        chk("same_second_we", 32'(bus.rf_we), 32'd1);

        // 7. reset mid-operation with a pending request
        bus.p0_valid = 1'b1;
        bus.p0_addr  = 5'd12;
        bus.p0_data  = 32'h1234_5678;
        reset        = 1'b1;
        #1;
        chk("midrst_p0_ready", 32'(bus.p0_ready), 32'd0);
        tick();
        chk("midrst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("midrst_rf_addr", 32'(bus.rf_addr), 32'd0);
        reset = 1'b0;
        #1;
        chk("postrst_p0_ready", 32'(bus.p0_ready), 32'd1);
        tick();
        bus.p0_valid = 1'b0;
        chk("postrst_rf_data", bus.rf_data, 32'h1234_5678);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscomp);
        $finish;
    end
endmodule
